// File: rtl/can_arb_pkg.sv
// can_arb_pkg: shared FSM state codes, AXI response code and
// CAN MAC register offsets for the AXI-Lite requester arbiter.
package can_arb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_WR_ADDR = 3'd1;
  localparam state_t S_WR_RESP = 3'd2;
  localparam state_t S_RD_ADDR = 3'd3;
  localparam state_t S_RD_RESP = 3'd4;
  localparam state_t S_DONE    = 3'd5;
  localparam state_t S_HUNG    = 3'd6;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam logic [7:0] REG_SRR    = 8'h00;
  localparam logic [7:0] REG_MODE   = 8'h04;
  localparam logic [7:0] REG_BRPR   = 8'h08;
  localparam logic [7:0] REG_BTR    = 8'h0C;
  localparam logic [7:0] REG_ISR    = 8'h1C;
  localparam logic [7:0] REG_ICR    = 8'h24;
  localparam logic [7:0] REG_TXFIFO = 8'h2C;
  localparam logic [7:0] REG_RXFIFO = 8'h50;

  function automatic logic resp_bad(input logic [1:0] r);
    return r != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/can_axil_if.sv
// can_axil_if: AXI4-Lite bundle between the arbiter (master)
// and the CAN MAC register slave (slave). Channels: AW, W, B, AR, R.
interface can_axil_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/can_axil_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, search starts at
// last_grant+1 and wraps. Ports: req, last_grant in; one-hot gnt out.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    int sum;
    logic [IDX_W-1:0] idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      sum = int'(last_grant) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = IDX_W'(sum);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/can_axil_arbiter.sv
// can_axil_arbiter: round-robin share of one AXI-Lite register port.
// Ports: clk, rst_n, req/req_we/req_addr/req_wdata in; ack, rsp_rdata,
// rsp_err, bus_hung out; m_axi master bundle. Option: CAN_ARB_TIMEOUT_EN.
module can_axil_arbiter
  import can_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      bus_hung,
  can_axil_if.master                m_axi
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535)
  begin : g_bad_cfg
    $error("can_axil_arbiter: parameter out of range");
  end

  state_t              state;
  logic [IDX_W-1:0]    last_grant;
  logic [IDX_W-1:0]    grant;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                arvalid_q;
  logic                rready_q;

  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                any_req;
  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   wdata_sel;
  logic                wr_acc;
  logic                b_hs;
  logic                r_hs;
  logic                tmo;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) gnt_idx = IDX_W'(i);
  end

  assign any_req   = |gnt;
  assign addr_sel  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign wdata_sel = req_wdata[gnt_idx*DATA_W +: DATA_W];

  // A channel counts as accepted if it already was, or is this cycle.
  assign wr_acc = (!awvalid_q || m_axi.awready) &&
                  (!wvalid_q  || m_axi.wready);
  assign b_hs   = bready_q && m_axi.bvalid;
  assign r_hs   = rready_q && m_axi.rvalid;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

`ifdef CAN_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);
  logic [15:0] cnt;
  logic        busy;
  logic        hung_q;

  assign busy = (state == S_WR_ADDR) || (state == S_WR_RESP) ||
                (state == S_RD_ADDR) || (state == S_RD_RESP);
  assign tmo  = busy && (cnt + 16'd1 == TMO_LIM);
  assign bus_hung = hung_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == S_IDLE && any_req) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + 16'd1;
    end
  end
`else
  assign tmo      = 1'b0;
  assign bus_hung = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      grant      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      ack        <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
`ifdef CAN_ARB_TIMEOUT_EN
      hung_q     <= 1'b0;
`endif
    end else begin
      ack       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            grant      <= gnt_idx;
            last_grant <= gnt_idx;
            addr_q     <= addr_sel;
            wdata_q    <= wdata_sel;
            if (req_we[gnt_idx]) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              bready_q  <= 1'b1;
              state     <= S_WR_ADDR;
            end else begin
              arvalid_q <= 1'b1;
              rready_q  <= 1'b1;
              state     <= S_RD_ADDR;
            end
          end
        end
        S_WR_ADDR: begin
          if (m_axi.awready) awvalid_q <= 1'b0;
          if (m_axi.wready)  wvalid_q  <= 1'b0;
          // bvalid only counts once both AW and W are through.
          if (wr_acc && b_hs) begin
            bready_q <= 1'b0;
            rsp_err  <= resp_bad(m_axi.bresp);
            ack      <= NUM_REQ'(1) << grant;
            state    <= S_DONE;
          end else if (wr_acc) begin
            state <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (b_hs) begin
            bready_q <= 1'b0;
            rsp_err  <= resp_bad(m_axi.bresp);
            ack      <= NUM_REQ'(1) << grant;
            state    <= S_DONE;
          end
        end
        S_RD_ADDR: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            state     <= S_RD_RESP;
          end
        end
        S_RD_RESP: begin
          if (r_hs) begin
            rready_q  <= 1'b0;
            rsp_rdata <= m_axi.rdata;
            rsp_err   <= resp_bad(m_axi.rresp);
            ack       <= NUM_REQ'(1) << grant;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
`ifdef CAN_ARB_TIMEOUT_EN
        S_HUNG: begin
          state <= S_HUNG;
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase
`ifdef CAN_ARB_TIMEOUT_EN
      // Abandon the slave; only reset recovers the port.
      if (tmo) begin
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        ack       <= NUM_REQ'(1) << grant;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
        hung_q    <= 1'b1;
        state     <= S_HUNG;
      end
`endif
    end
  end

endmodule

// File: tb/tb_can_axil_arbiter.sv
// tb_can_axil_arbiter: directed checks of grant order, AXI-Lite
// handshakes, error and reset behaviour of can_axil_arbiter.
module tb_can_axil_arbiter;
  import can_arb_pkg::*;

  localparam int N   = 3;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            bus_hung;

  int total = 0;
  int bad   = 0;

  can_axil_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  can_axil_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus_hung  (bus_hung),
    .m_axi     (axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i]          = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req[i]             = 1'b1;
  endtask

  // Zero-wait slave: ready in cycle 1, response in cycle 2,
  // returns what is on the response port in cycle 3.
  task automatic zw(input logic [1:0] resp, input logic [31:0] rd,
                    output logic [N-1:0] a, output logic e,
                    output logic [31:0] d);
    tick;
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    axi.arready = 1'b1;
    tick;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.arready = 1'b0;
    axi.bvalid  = 1'b1;
    axi.rvalid  = 1'b1;
    axi.bresp   = resp;
    axi.rresp   = resp;
    axi.rdata   = rd;
    tick;
    axi.bvalid  = 1'b0;
    axi.rvalid  = 1'b0;
    a = ack;
    e = rsp_err;
    d = rsp_rdata;
  endtask

  function automatic logic [4:0] valids();
    return {axi.awvalid, axi.wvalid, axi.bready,
            axi.arvalid, axi.rready};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] a;
    logic         e;
    logic [31:0]  d;
    logic [N-1:0] acc;
    int           nack;
    int           got;

    rst_n       = 1'b0;
    req         = '0;
    req_we      = '0;
    req_addr    = '0;
    req_wdata   = '0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rresp   = 2'b00;
    axi.rdata   = '0;
    repeat (2) tick;

    chk("rst_valids", 32'(valids()), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    chk("rst_hung", 32'(bus_hung), 32'h0);
    rst_n = 1'b1;
    tick;

    // single write, zero-wait slave
    set_req(1, 1'b1, REG_BTR, 32'hB8);
    tick;
    chk("wr_valids", 32'(valids()), 32'b11100);
    chk("wr_awaddr", 32'(axi.awaddr), 32'h0C);
    chk("wr_wdata", axi.wdata, 32'hB8);
    chk("wr_wstrb", 32'(axi.wstrb), 32'hF);
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    tick;
    chk("wr_vdrop", 32'({axi.awvalid, axi.wvalid}), 32'h0);
    chk("wr_noack2", 32'(ack), 32'h0);
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b1;
    axi.bresp   = 2'b00;
    tick;
    chk("wr_ack3", 32'(ack), 32'b010);
    chk("wr_err", 32'(rsp_err), 32'h0);
    chk("wr_rdata", rsp_rdata, 32'h0);
    chk("wr_bready", 32'(axi.bready), 32'h0);
    axi.bvalid = 1'b0;
    req[1]     = 1'b0;
    tick;
    chk("wr_ack4", 32'(ack), 32'h0);

    // single read, rvalid after 5 wait cycles
    set_req(2, 1'b0, REG_ISR, 32'h0);
    tick;
    chk("rd_valids", 32'(valids()), 32'b00011);
    chk("rd_araddr", 32'(axi.araddr), 32'h1C);
    axi.arready = 1'b1;
    tick;
    axi.arready = 1'b0;
    req_addr[2*AW +: AW] = REG_MODE;
    chk("rd_ardrop", 32'(axi.arvalid), 32'h0);
    acc = '0;
    repeat (5) begin
      acc |= ack;
      tick;
    end
    acc |= ack;
    chk("rd_wait_ack", 32'(acc), 32'h0);
    chk("rd_latched", 32'(axi.araddr), 32'h1C);
    axi.rvalid = 1'b1;
    axi.rdata  = 32'h12;
    axi.rresp  = 2'b00;
    tick;
    chk("rd_ack", 32'(ack), 32'b100);
    chk("rd_rdata", rsp_rdata, 32'h12);
    chk("rd_err", 32'(rsp_err), 32'h0);
    axi.rvalid = 1'b0;
    req[2]     = 1'b0;
    tick;

    // fairness: all requesters held for 9 transactions
    set_req(0, 1'b1, REG_SRR, 32'h1);
    set_req(1, 1'b0, REG_ISR, 32'h0);
    set_req(2, 1'b1, REG_ICR, 32'hFF);
    for (int i = 0; i < 9; i++) begin
      zw(2'b00, 32'h100 + 32'(i), a, e, d);
      chk($sformatf("fair%0d", i), 32'(a), 32'(1 << (i % 3)));
      if (i == 8) req = '0;
      tick;
    end

    // skewed AW/W acceptance with early, held bvalid
    set_req(0, 1'b1, REG_TXFIFO, 32'hA5);
    tick;
    axi.awready = 1'b1;
    tick;
    axi.awready = 1'b0;
    chk("skew_c2", 32'({axi.awvalid, axi.wvalid}), 32'b01);
    axi.bvalid = 1'b1;
    axi.bresp  = 2'b00;
    tick;
    chk("skew_c3", 32'({axi.wvalid, ack}), 32'b1000);
    tick;
    chk("skew_c4", 32'({axi.wvalid, ack}), 32'b1000);
    axi.wready = 1'b1;
    tick;
    axi.wready = 1'b0;
    chk("skew_wdrop", 32'(axi.wvalid), 32'h0);
    nack = 0;
    for (int k = 0; k < 6; k++) begin
      if (ack != '0) begin
        nack++;
        chk("skew_who", 32'(ack), 32'b001);
        axi.bvalid = 1'b0;
        req[0]     = 1'b0;
      end
      tick;
    end
    chk("skew_nack", 32'(nack), 32'd1);
    axi.bvalid = 1'b0;
    req        = '0;
    tick;

    // error response, then a clean one
    set_req(1, 1'b0, REG_RXFIFO, 32'h0);
    zw(2'b10, 32'hDEAD, a, e, d);
    chk("err_ack", 32'(a), 32'b010);
    chk("err_flag", 32'(e), 32'h1);
    chk("err_rdata", d, 32'hDEAD);
    req[1] = 1'b0;
    tick;
    set_req(2, 1'b1, REG_ICR, 32'h1);
    zw(2'b00, 32'h0, a, e, d);
    chk("ok_ack", 32'(a), 32'b100);
    chk("ok_flag", 32'(e), 32'h0);
    req[2] = 1'b0;
    tick;

    // reset mid-transaction aborts and restores last_grant
    set_req(0, 1'b1, REG_MODE, 32'h1);
    set_req(1, 1'b0, REG_ISR, 32'h0);
    tick;
    chk("abort_pre", 32'(axi.awvalid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_valids", 32'(valids()), 32'h0);
    acc = ack;
    repeat (3) begin
      tick;
      acc |= ack;
    end
    chk("abort_noack", 32'(acc), 32'h0);
    rst_n = 1'b1;
    zw(2'b00, 32'h0, a, e, d);
    chk("abort_first", 32'(a), 32'b001);
    req[0] = 1'b0;
    tick;
    zw(2'b00, 32'h0, a, e, d);
    chk("abort_second", 32'(a), 32'b010);
    req = '0;
    tick;

`ifdef CAN_ARB_TIMEOUT_EN
    // slave never takes AW: timeout ack, sticky hang
    set_req(0, 1'b1, REG_BTR, 32'h5);
    got = -1;
    a   = '0;
    e   = 1'b0;
    d   = 32'hFFFF_FFFF;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (ack != '0 && got < 0) begin
        got = k;
        a   = ack;
        e   = rsp_err;
        d   = rsp_rdata;
        req[0] = 1'b0;
      end
    end
    chk("tmo_cycle", 32'(got), 32'(TMO + 1));
    chk("tmo_ack", 32'(a), 32'b001);
    chk("tmo_err", 32'(e), 32'h1);
    chk("tmo_rdata", d, 32'h0);
    chk("tmo_hung", 32'(bus_hung), 32'h1);
    chk("tmo_valids", 32'(valids()), 32'h0);
    set_req(1, 1'b0, REG_ISR, 32'h0);
    acc = '0;
    repeat (10) begin
      tick;
      acc |= ack;
    end
    chk("hung_noack", 32'(acc), 32'h0);
    chk("hung_valids", 32'(valids()), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("hung_clear", 32'(bus_hung), 32'h0);
    req = '0;
    tick;
    rst_n = 1'b1;
    tick;
`else
    chk("hung_tied", 32'(bus_hung), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
